// File: rtl/router_pkg.sv
// Shared definitions for the router output arbiter: flit type codes,
// source indices, FSM state encoding and small index helpers.
package router_pkg;

    localparam logic [1:0] FLIT_EMPTY = 2'b00;
    localparam logic [1:0] FLIT_HEAD  = 2'b01;
    localparam logic [1:0] FLIT_BODY  = 2'b10;
    localparam logic [1:0] FLIT_TAIL  = 2'b11;

    localparam logic [1:0] SRC_VC0 = 2'd0;
    localparam logic [1:0] SRC_VC1 = 2'd1;
    localparam logic [1:0] SRC_NI  = 2'd2;
    localparam int         NUM_SRC = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Round-robin successor; an out-of-range index wraps to VC0.
    function automatic logic [1:0] next_src(input logic [1:0] s);
        case (s)
            SRC_VC0: return SRC_VC1;
            SRC_VC1: return SRC_NI;
            default: return SRC_VC0;
        endcase
    endfunction

    function automatic logic [1:0] onehot_to_src(input logic [2:0] oh);
        if (oh[2]) return SRC_NI;
        if (oh[1]) return SRC_VC1;
        return SRC_VC0;
    endfunction

endpackage

// File: rtl/router_out_arbiter_if.sv
// Signal bundle between the flit sources/downstream link and the output arbiter.
// wd_abort exists only when ARB_WATCHDOG_EN is defined.
interface router_out_arbiter_if #(
    parameter int CW = 3
);
    logic [7:0]    flit_vc0;
    logic [7:0]    flit_vc1;
    logic [7:0]    flit_ni;
    logic          credit_in;
    logic [2:0]    pop;
    logic [2:0]    grant;
    logic [7:0]    flit_out_down;
    logic          out_valid;
    logic [CW-1:0] credits;
    logic          stray;
`ifdef ARB_WATCHDOG_EN
    logic          wd_abort;

    modport master (
        input  flit_vc0, flit_vc1, flit_ni, credit_in,
        output pop, grant, flit_out_down, out_valid, credits, stray, wd_abort
    );
    modport slave (
        output flit_vc0, flit_vc1, flit_ni, credit_in,
        input  pop, grant, flit_out_down, out_valid, credits, stray, wd_abort
    );
`else
    modport master (
        input  flit_vc0, flit_vc1, flit_ni, credit_in,
        output pop, grant, flit_out_down, out_valid, credits, stray
    );
    modport slave (
        output flit_vc0, flit_vc1, flit_ni, credit_in,
        input  pop, grant, flit_out_down, out_valid, credits, stray
    );
`endif
endinterface

// File: rtl/rr_arbiter3.sv
// Combinational 3-way round-robin pick: search starts at the source after 'last'.
module rr_arbiter3
    import router_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] gnt
);
    logic [1:0] cand0;
    logic [1:0] cand1;
    logic [1:0] cand2;

    assign cand0 = next_src(last);
    assign cand1 = next_src(cand0);
    assign cand2 = next_src(cand1);

    always_comb begin
        gnt = 3'b000;
        if (req[cand0])      gnt[cand0] = 1'b1;
        else if (req[cand1]) gnt[cand1] = 1'b1;
        else if (req[cand2]) gnt[cand2] = 1'b1;
    end
endmodule

// File: rtl/router_out_arbiter.sv
// Wormhole-locking, credit-flow-controlled output arbiter for VC0/VC1/NI sources.
// Optional lock watchdog enabled by defining ARB_WATCHDOG_EN.
module router_out_arbiter
    import router_pkg::*;
#(
    parameter int CREDITS   = 4,
    parameter int CW        = 3,
    parameter int WD_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    router_out_arbiter_if.master bus
);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    arb_state_t    state_reg, state_next;
    logic [1:0]    owner_reg, owner_next;
    logic [1:0]    last_reg, last_next;
    logic [2:0]    grant_reg, grant_next;
    logic [7:0]    flit_out_reg;
    logic          out_valid_reg;
    logic [CW-1:0] credits_reg, credits_next;
    logic          stray_reg, stray_next;

    logic [7:0]         flit_src [NUM_SRC];
    logic [1:0]         ftype    [NUM_SRC];
    logic [NUM_SRC-1:0] head_req;
    logic [NUM_SRC-1:0] stray_req;
    logic [2:0]         arb_req;
    logic [2:0]         rr_gnt;
    logic [2:0]         pop_c;
    logic               has_credit;
    logic               send;
    logic [7:0]         send_flit;
    logic [1:0]         owner_type;
    logic               wd_hit;

    assign flit_src[0] = bus.flit_vc0;
    assign flit_src[1] = bus.flit_vc1;
    assign flit_src[2] = bus.flit_ni;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign ftype[gi]     = flit_src[gi][7:6];
            assign head_req[gi]  = (ftype[gi] == FLIT_HEAD);
            assign stray_req[gi] = (ftype[gi] == FLIT_BODY) || (ftype[gi] == FLIT_TAIL);
        end
    endgenerate

    assign has_credit = (credits_reg != '0);
    assign arb_req    = head_req & {3{has_credit}};
    assign owner_type = ftype[owner_reg];

    rr_arbiter3 u_rr (
        .req  (arb_req),
        .last (last_reg),
        .gnt  (rr_gnt)
    );

`ifdef ARB_WATCHDOG_EN
    localparam int WDW = $clog2(WD_CYCLES + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(WD_CYCLES - 1);
    logic [WDW-1:0] wd_cnt_reg, wd_cnt_next;
    logic           wd_abort_reg;

    assign wd_hit = (state_reg == ST_LOCKED) && (owner_type == FLIT_EMPTY)
                    && has_credit && (wd_cnt_reg == WD_LAST);
`else
    assign wd_hit = 1'b0;
`endif

    // Stray discards and the round-robin winner never overlap: one is body/tail, the other a head.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        grant_next = grant_reg;
        pop_c      = 3'b000;
        send       = 1'b0;
        send_flit  = flit_src[owner_reg];
        stray_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                pop_c      = stray_req | rr_gnt;
                stray_next = |stray_req;
                if (|rr_gnt) begin
                    send       = 1'b1;
                    send_flit  = flit_src[onehot_to_src(rr_gnt)];
                    state_next = ST_LOCKED;
                    owner_next = onehot_to_src(rr_gnt);
                    last_next  = onehot_to_src(rr_gnt);
                    grant_next = rr_gnt;
                end
            end
            ST_LOCKED: begin
                // An owner head here is a protocol error and is simply held.
                if (has_credit && (owner_type == FLIT_BODY || owner_type == FLIT_TAIL)) begin
                    send             = 1'b1;
                    pop_c[owner_reg] = 1'b1;
                    if (owner_type == FLIT_TAIL) begin
                        state_next = ST_IDLE;
                        grant_next = 3'b000;
                    end
                end else if (wd_hit) begin
                    state_next = ST_IDLE;
                    grant_next = 3'b000;
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = 3'b000;
            end
        endcase
    end

    always_comb begin
        credits_next = credits_reg;
        if (send && !bus.credit_in)
            credits_next = credits_reg - 1'b1;
        else if (!send && bus.credit_in && credits_reg != CRED_MAX)
            credits_next = credits_reg + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= SRC_VC0;
            last_reg      <= SRC_NI;
            grant_reg     <= 3'b000;
            flit_out_reg  <= 8'h00;
            out_valid_reg <= 1'b0;
            credits_reg   <= CRED_MAX;
            stray_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            last_reg      <= last_next;
            grant_reg     <= grant_next;
            if (send) flit_out_reg <= send_flit;
            out_valid_reg <= send;
            credits_reg   <= credits_next;
            stray_reg     <= stray_next;
        end
    end

`ifdef ARB_WATCHDOG_EN
    // Counts owner idle cycles with credit available; a credit stall freezes it.
    always_comb begin
        wd_cnt_next = wd_cnt_reg;
        if (state_next != ST_LOCKED || send)
            wd_cnt_next = '0;
        else if (has_credit && wd_cnt_reg != WD_LAST)
            wd_cnt_next = wd_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_reg   <= '0;
            wd_abort_reg <= 1'b0;
        end else begin
            wd_cnt_reg   <= wd_cnt_next;
            wd_abort_reg <= wd_hit && !send;
        end
    end

    assign bus.wd_abort = wd_abort_reg;
`endif

    assign bus.pop           = pop_c;
    assign bus.grant         = grant_reg;
    assign bus.flit_out_down = flit_out_reg;
    assign bus.out_valid     = out_valid_reg;
    assign bus.credits       = credits_reg;
    assign bus.stray         = stray_reg;
endmodule

// File: doc/router_out_arbiter.md
Name: router_out_arbiter

Overview:
- Sequences the router's down-link output among three flit sources: VC0, VC1 and the NI buffer.
- Applies wormhole locking: a head flit wins the output, and that source owns it until its tail flit.
- Fair round-robin selection between packets; credit-based flow control toward the downstream node.
- Sits between the virtual-channel buffers and the crossbar. It generates the select and pop signals and registers the outgoing flit.

Parameters:
- CREDITS, 4, downstream buffer depth; reset value and ceiling of the credit counter.
- CW, 3, credit counter width; must hold CREDITS.
- WD_CYCLES, 16, watchdog limit in cycles (used only with ARB_WATCHDOG_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flit_vc0  in  8  head-of-queue flit from VC0.
- flit_vc1  in  8  head-of-queue flit from VC1.
- flit_ni  in  8  head-of-queue flit from NI buffer.
- credit_in  in  1  one-cycle pulse from downstream: one buffer slot freed.
- pop  out  3  one-hot, combinational; source i's flit is consumed this cycle (bit0 VC0, bit1 VC1, bit2 NI).
- grant  out  3  one-hot registered owner of the output; 000 when idle.
- flit_out_down  out  8  registered output flit.
- out_valid  out  1  registered; flit_out_down is valid this cycle.
- credits  out  CW  current credit count.
- stray  out  1  registered pulse: a non-head flit arrived at an unlocked source and was discarded.

Behaviour:
- Flit type field is flit[7:6]:
  - 00 = empty
  - 01 = head (dest in [5:4])
  - 10 = body
  - 11 = tail
- A source is valid when its type is not 00. Packets are at least 2 flits (head…tail).
- Reset values:
  - grant = 000, out_valid = 0, flit_out_down = 8'h00, stray = 0.
  - credits = CREDITS; RR pointer = VC0 (highest priority after reset).
  - FSM = IDLE.
- FSM states:
  - IDLE:
    - If credits > 0 and any source presents a head, pick one by round-robin, starting at the source after last_winner.
    - Same cycle: pop[w] = 1. Next edge: flit_out_down = head, out_valid = 1, grant = onehot(w), last_winner = w, state = LOCKED.
    - If credits == 0, nothing is picked and there is no pop.
  - LOCKED:
    - Only the owner is eligible. Its body/tail flit is sent when credits > 0: pop same cycle, output next cycle.
    - After the tail is sent, the next edge gives grant = 000 and state = IDLE. The FSM must return to IDLE before arbitrating again, so there is one idle cycle between packets.
    - A head at the owner while LOCKED is a protocol error: not popped, held until the owner's tail.
    - Non-owner sources are never popped.
- Stray flits: in IDLE, any source presenting body or tail is popped and discarded (not sent). stray pulses the next cycle. Stray discard does not consume credit, and it takes priority over that source's arbitration in the same cycle.
- Latency: 1 cycle from pop to out_valid. Throughput is 1 flit/cycle while credits > 0.
- Credits:
  - Decrement on each sent flit; increment on credit_in.
  - Simultaneous send and credit_in: unchanged.
  - At credits == CREDITS, credit_in is ignored (saturates).
  - Never underflows, because a send requires credits > 0.
- out_valid is 0 in any cycle following no send; flit_out_down holds its last value.
- A reset mid-packet drops the lock and restores credits immediately (asynchronous); no partial packet completion.

Optional Feature:
- Macro: ARB_WATCHDOG_EN.
- Defined:
  - A counter runs in LOCKED and clears on every owner send.
  - When it reaches WD_CYCLES with the owner presenting empty while credits > 0, the lock is force-released: grant = 000, state = IDLE, and the port wd_abort (out, 1) pulses for one cycle.
  - A credit stall (credits == 0) does not advance the counter.
- Undefined: no counter, no wd_abort port; the lock holds indefinitely.

Decomposition:
- Package router_pkg:
  - flit type constants FLIT_EMPTY / HEAD / BODY / TAIL;
  - source indices SRC_VC0 / VC1 / NI;
  - FSM state encoding ST_IDLE / ST_LOCKED.
- Sub-module rr_arbiter3: combinational 3-way round-robin pick (req[2:0], last[1:0] -> gnt one-hot). It is reusable for the NI output port.

Test Plan:
- Single packet: VC0 presents 8'h50, 8'h8A, 8'hC3 on consecutive cycles with credits 4 -> pop[0] on 3 cycles; flit_out_down 50/8A/C3 with 1-cycle lag; grant 001 until after the tail; credits 4->1.
- Contention: all three sources present heads simultaneously after reset -> order VC0, VC1, NI, with each packet completing before the next grant; a repeat picks VC0 again after NI.
- Credit stall: CREDITS = 2, no credit_in, 4-flit packet -> 2 flits sent, pop = 0 and out_valid = 0 thereafter. One credit_in pulse -> exactly one more flit. Simultaneous send and credit_in keeps the count.
- Stray: VC1 presents 8'h8F while idle -> pop[1] = 1, no out_valid, stray pulses once, credits unchanged.
- Reset mid-packet: assert rst after the head of a 3-flit packet -> grant = 000, credits = CREDITS, out_valid = 0 asynchronously. After release, a new head from NI is granted normally.
- Watchdog (ARB_WATCHDOG_EN): owner sends the head, then goes empty for 16 cycles with credits > 0 -> wd_abort pulses, grant = 000, and a pending VC1 head wins next.
